// File: rtl/cpu_mul_arbiter.sv
// Round-robin arbiter sharing one registered multiply cell between two requesters.
// One operation in flight; the result is held in a response register until the owner takes it.
module cpu_mul_arbiter #(
   parameter int DATA_W      = 32,
   parameter int MUL_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_src1,
   input  logic [DATA_W-1:0] req0_src2,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic [DATA_W-1:0] rsp0_result,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_src1,
   input  logic [DATA_W-1:0] req1_src2,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp1_result,
   output logic [DATA_W-1:0] M_mul_src1,
   output logic [DATA_W-1:0] M_mul_src2,
   input  logic [DATA_W-1:0] M_mul_cell_result
);

   // state  | meaning
   // S_IDLE | no operation in flight; arbitration and grant happen only here
   // S_WAIT | operands on the cell; counting down until the cell result is valid
   // S_RESP | result held for the owner until its response handshake
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam int CNT_W = 3;

   state_t            state_q;
   state_t            state_d;
   logic              owner_q;
   logic              last_grant_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] src1_q;
   logic [DATA_W-1:0] src2_q;
   logic [DATA_W-1:0] result_q;
   logic              grant0;
   logic              grant1;
   logic              rsp_hs;

   always_comb begin
      state_d = state_q;
      grant0  = 1'b0;
      grant1  = 1'b0;
      rsp_hs  = 1'b0;
      case (state_q)
         S_IDLE: begin
            // on a tie the requester that was not granted last wins
            if (req0_valid && (!req1_valid || last_grant_q)) begin
               grant0 = 1'b1;
            end else if (req1_valid) begin
               grant1 = 1'b1;
            end
            if (grant0 || grant1) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            rsp_hs = owner_q ? rsp1_ready : rsp0_ready;
            if (rsp_hs) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
         src1_q       <= '0;
         src2_q       <= '0;
         result_q     <= '0;
      end else begin
         state_q <= state_d;
         if (grant0 || grant1) begin
            src1_q       <= grant1 ? req1_src1 : req0_src1;
            src2_q       <= grant1 ? req1_src2 : req0_src2;
            owner_q      <= grant1;
            last_grant_q <= grant1;
            cnt_q        <= CNT_W'(MUL_LATENCY);
         end
         if (state_q == S_WAIT) begin
            if (cnt_q != '0) begin
               cnt_q <= cnt_q - 1'b1;
            end else begin
               result_q <= M_mul_cell_result;
            end
         end
      end
   end

   assign req0_ready  = grant0;
   assign req1_ready  = grant1;
   assign rsp0_valid  = (state_q == S_RESP) && !owner_q;
   assign rsp1_valid  = (state_q == S_RESP) && owner_q;
   // only the owner sees the held result; the other side reads zero
   assign rsp0_result = owner_q ? '0 : result_q;
   assign rsp1_result = owner_q ? result_q : '0;
   assign M_mul_src1  = src1_q;
   assign M_mul_src2  = src2_q;

endmodule

// File: tb/tb_cpu_mul_arbiter.sv
// Scoreboard bench for cpu_mul_arbiter: directed scenarios then randomized traffic,
// with a registered multiply-cell model and an arbitration/latency reference model.
module tb_cpu_mul_arbiter;
   localparam int DW  = 32;
   localparam int LAT = 1;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [1:0]    req_valid = '0;
   logic [1:0]    req_ready;
   logic [DW-1:0] req_src1 [2];
   logic [DW-1:0] req_src2 [2];
   logic [1:0]    rsp_valid;
   logic [1:0]    rsp_ready = '0;
   logic [DW-1:0] rsp_result [2];
   logic [DW-1:0] M_mul_src1;
   logic [DW-1:0] M_mul_src2;
   logic [DW-1:0] M_mul_cell_result;
   logic [DW-1:0] cell_pipe [LAT];

   cpu_mul_arbiter #(.DATA_W(DW), .MUL_LATENCY(LAT)) dut (
      .clk(clk), .reset_n(reset_n),
      .req0_valid(req_valid[0]), .req0_ready(req_ready[0]),
      .req0_src1(req_src1[0]), .req0_src2(req_src2[0]),
      .rsp0_valid(rsp_valid[0]), .rsp0_ready(rsp_ready[0]), .rsp0_result(rsp_result[0]),
      .req1_valid(req_valid[1]), .req1_ready(req_ready[1]),
      .req1_src1(req_src1[1]), .req1_src2(req_src2[1]),
      .rsp1_valid(rsp_valid[1]), .rsp1_ready(rsp_ready[1]), .rsp1_result(rsp_result[1]),
      .M_mul_src1(M_mul_src1), .M_mul_src2(M_mul_src2),
      .M_mul_cell_result(M_mul_cell_result)
   );

   always #5 clk = ~clk;

   // multiply cell: LAT-stage registered product, cleared by the same reset
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < LAT; i++) cell_pipe[i] <= '0;
      end else begin
         cell_pipe[0] <= M_mul_src1 * M_mul_src2;
         for (int i = 1; i < LAT; i++) cell_pipe[i] <= cell_pipe[i-1];
      end
   end
   assign M_mul_cell_result = cell_pipe[LAT-1];

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // reference model state (owned by the monitor)
   bit            busy_m = 1'b0;
   bit            owner_m = 1'b0;
   bit            last_m = 1'b1;
   int            grant_cyc = 0;
   logic [DW-1:0] op_a, op_b;
   logic [DW-1:0] exp_q0[$];
   logic [DW-1:0] exp_q1[$];
   int            granted [2] = '{0, 0};
   logic [1:0]    exp_rdy, exp_vld;
   logic [63:0]   prod;
   bit            gn;

   // stimulus state (owned by the main process)
   logic [63:0]   stim_q0[$];
   logic [63:0]   stim_q1[$];
   int            issued [2] = '{0, 0};
   bit            rand_rdy = 1'b0;
   bit            hold_rdy [2] = '{1'b0, 1'b0};
   int            gap_pct = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // monitor: samples on the falling edge, where inputs and outputs are settled for the next rising edge
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset_n) begin
            chk("reset_req_ready", {30'd0, req_ready}, '0);
            chk("reset_rsp_valid", {30'd0, rsp_valid}, '0);
            chk("reset_mul_src1", M_mul_src1, '0);
            chk("reset_mul_src2", M_mul_src2, '0);
            chk("reset_rsp0_result", rsp_result[0], '0);
            chk("reset_rsp1_result", rsp_result[1], '0);
            busy_m  = 1'b0;
            owner_m = 1'b0;
            last_m  = 1'b1;
            exp_q0.delete();
            exp_q1.delete();
         end else begin
            exp_rdy = '0;
            if (!busy_m) begin
               if (req_valid == 2'b11) exp_rdy = last_m ? 2'b01 : 2'b10;
               else exp_rdy = req_valid;
            end
            chk("req_ready", {30'd0, req_ready}, {30'd0, exp_rdy});

            exp_vld = '0;
            if (busy_m && (cyc >= grant_cyc + LAT + 2)) exp_vld[owner_m] = 1'b1;
            chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, exp_vld});
            chk("nonowner_result", rsp_result[owner_m ? 0 : 1], '0);
            if (busy_m && cyc > grant_cyc) begin
               chk("mul_src1_held", M_mul_src1, op_a);
               chk("mul_src2_held", M_mul_src2, op_b);
            end
            if (exp_vld != 2'b00) begin
               chk("rsp_result", rsp_result[owner_m], owner_m ? exp_q1[0] : exp_q0[0]);
               if (rsp_ready[owner_m]) begin
                  if (owner_m) void'(exp_q1.pop_front());
                  else void'(exp_q0.pop_front());
                  busy_m = 1'b0;
               end
            end

            if (exp_rdy != 2'b00) begin
               gn      = exp_rdy[1];
               op_a    = req_src1[gn];
               op_b    = req_src2[gn];
               prod    = {32'd0, op_a} * {32'd0, op_b};
               if (gn) exp_q1.push_back(prod[DW-1:0]);
               else exp_q0.push_back(prod[DW-1:0]);
               busy_m    = 1'b1;
               owner_m   = gn;
               last_m    = gn;
               grant_cyc = cyc;
               granted[gn]++;
            end
         end
      end
   end

   task automatic push_op(input int n, input logic [DW-1:0] a, input logic [DW-1:0] b);
      if (n == 0) stim_q0.push_back({a, b});
      else stim_q1.push_back({a, b});
   endtask

   task automatic drive_req(input int n);
      logic [63:0] v;
      bit          have;
      if (issued[n] == granted[n]) begin
         req_valid[n] = 1'b0;
         have = (n == 0) ? (stim_q0.size() > 0) : (stim_q1.size() > 0);
         if (have && ($urandom_range(99) >= gap_pct)) begin
            v = (n == 0) ? stim_q0.pop_front() : stim_q1.pop_front();
            req_src1[n]  = v[63:32];
            req_src2[n]  = v[31:0];
            req_valid[n] = 1'b1;
            issued[n]++;
         end
      end
      rsp_ready[n] = hold_rdy[n] ? 1'b0 : (rand_rdy ? 1'($urandom_range(1)) : 1'b1);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      drive_req(0);
      drive_req(1);
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      req_valid = '0;
      stim_q0.delete();
      stim_q1.delete();
      issued[0] = granted[0];
      issued[1] = granted[1];
      repeat (2) step();
      reset_n = 1'b1;
   endtask

   task automatic wait_drain(input string name, input int max_cyc);
      int k = 0;
      while ((stim_q0.size() > 0 || stim_q1.size() > 0 || issued[0] != granted[0] ||
              issued[1] != granted[1] || busy_m) && k < max_cyc) begin
         step();
         k++;
      end
      checks++;
      if (k >= max_cyc) begin
         errors++;
         $display("FAIL %s: drain timeout after %0d cycles, expected idle", name, k);
      end
   endtask

   function automatic logic [DW-1:0] rand_operand();
      case ($urandom_range(3))
         0:       return $urandom_range(15);
         1:       return 32'hFFFF_FFFF - $urandom_range(3);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int k;
      int g;
      req_src1[0] = '0; req_src2[0] = '0;
      req_src1[1] = '0; req_src2[1] = '0;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      step();

      // simultaneous requests right after reset: req0 first, then strict alternation
      push_op(0, 32'd3, 32'd4);  push_op(1, 32'd5, 32'd6);
      push_op(0, 32'd8, 32'd9);  push_op(1, 32'd10, 32'd11);
      wait_drain("round_robin", 100);

      push_op(0, 32'd7, 32'd6);
      wait_drain("single_req0", 50);

      push_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      push_op(1, 32'h1234_5678, 32'h0000_0010);
      push_op(0, 32'h0001_0000, 32'h0001_0000);
      wait_drain("wrap", 100);

      // backpressure on rsp0 while req1 waits
      hold_rdy[0] = 1'b1;
      push_op(0, 32'd9, 32'd9);
      k = 0;
      while (!rsp_valid[0] && k < 20) begin step(); k++; end
      checks++;
      if (k >= 20) begin
         errors++;
         $display("FAIL backpressure_rsp0: rsp0_valid still %b, expected 1", rsp_valid[0]);
      end
      push_op(1, 32'd2, 32'd3);
      repeat (5) step();
      hold_rdy[0] = 1'b0;
      wait_drain("backpressure", 50);

      // reset during the WAIT of a req1 operation
      push_op(1, 32'd11, 32'd13);
      g = granted[1];
      k = 0;
      while (granted[1] == g && k < 20) begin step(); k++; end
      checks++;
      if (k >= 20) begin
         errors++;
         $display("FAIL reset_wait_grant: req1 grant count %0d, expected %0d", granted[1], g + 1);
      end
      do_reset();
      repeat (6) step();
      push_op(1, 32'd3, 32'd5);
      wait_drain("after_reset", 50);

      // randomized traffic with random gaps and response backpressure
      rand_rdy = 1'b1;
      gap_pct  = 30;
      for (int i = 0; i < 300; i++) begin
         push_op(0, rand_operand(), rand_operand());
         push_op(1, rand_operand(), rand_operand());
      end
      wait_drain("random", 20000);
      rand_rdy = 1'b0;
      gap_pct  = 0;
      repeat (3) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
